// File: rtl/alu_operand_stage.sv
// alu_operand_stage: decode and operand fetch in front of the 16-bit ALU.
// Holds a 16x16 register file (with a writeback port), decodes one instruction
// per handshake into an operand bundle, and buffers up to two bundles
// (output register plus skid) so that in_ready comes straight from a flop.
module alu_operand_stage #(
  parameter int WIDTH   = 16,
  parameter int REGS    = 16,
  parameter int CTL_LEN = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [15:0]        instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTL_LEN-1:0] operationControl,
  output logic [WIDTH-1:0]   sourceData,
  output logic [WIDTH-1:0]   destData,
  output logic               alu_enable,
  output logic               wb_req,
  output logic [3:0]         wb_dest,
  output logic               illegal,
  input  logic               wb_en,
  input  logic [3:0]         wb_addr,
  input  logic [WIDTH-1:0]   wb_data
);

  // One buffered operand bundle. *_snp marks an operand that came from a
  // register (and so must track later writebacks); *_idx is that register.
  typedef struct packed {
    logic [CTL_LEN-1:0] ctl;
    logic [WIDTH-1:0]   src;
    logic [WIDTH-1:0]   dst;
    logic               wb_req;
    logic [3:0]         wb_dest;
    logic               illegal;
    logic               src_snp;
    logic [3:0]         src_idx;
    logic               dst_snp;
    logic [3:0]         dst_idx;
  } entry_t;

  // Replace any register-sourced operand whose index matches this cycle's write.
  function automatic entry_t snoop_entry(input entry_t e, input logic en,
                                         input logic [3:0] a, input logic [WIDTH-1:0] d);
    entry_t r;
    r = e;
    if (en && e.src_snp && (e.src_idx == a)) r.src = d;
    if (en && e.dst_snp && (e.dst_idx == a)) r.dst = d;
    return r;
  endfunction

  // ---------------------------------------------------------------- register file
  logic [WIDTH-1:0] rf_reg [REGS];
  logic [REGS-1:0]  rf_we;

  genvar gi;
  generate
    for (gi = 0; gi < REGS; gi++) begin : g_rf_we
      assign rf_we[gi] = wb_en && (wb_addr == 4'(gi));
    end
  endgenerate

  // Register file update: cleared on reset (writes ignored then), else written by wb.
  always_ff @(posedge clk) begin
    for (int i = 0; i < REGS; i++) begin
      if (!reset_n) begin
        rf_reg[i] <= '0;
      end else if (rf_we[i]) begin
        rf_reg[i] <= wb_data;
      end
    end
  end

  // ---------------------------------------------------------------- decode
  logic [3:0]       op, rd, ext, rs;
  logic [WIDTH-1:0] rs_data, rd_data, imm_s, imm_z;

  assign op  = instr[15:12];
  assign rd  = instr[11:8];
  assign ext = instr[7:4];
  assign rs  = instr[3:0];

  // Same-cycle writeback bypass on both read ports.
  assign rs_data = (wb_en && (wb_addr == rs)) ? wb_data : rf_reg[rs];
  assign rd_data = (wb_en && (wb_addr == rd)) ? wb_data : rf_reg[rd];

  assign imm_s = {{(WIDTH-8){instr[7]}}, instr[7:0]};
  assign imm_z = {{(WIDTH-8){1'b0}}, instr[7:0]};

  entry_t new_e;

  // Build the operand bundle for the instruction currently offered.
  always_comb begin
    new_e         = '0;
    new_e.wb_dest = rd;
    new_e.wb_req  = 1'b1;
    unique case (op)
      4'b0000: begin  // RTYPE
        new_e.ctl     = {op, ext};
        new_e.src     = rs_data;
        new_e.src_snp = 1'b1;
        new_e.src_idx = rs;
        new_e.dst     = rd_data;
        new_e.dst_snp = 1'b1;
        new_e.dst_idx = rd;
        new_e.wb_req  = (ext != 4'b1011);  // CMP only sets flags
      end
      4'b1000: begin  // SHIFT
        unique case (ext)
          4'b0100, 4'b0110: begin
            new_e.ctl     = {op, ext};
            new_e.src     = rs_data;
            new_e.src_snp = 1'b1;
            new_e.src_idx = rs;
            new_e.dst     = rd_data;
            new_e.dst_snp = 1'b1;
            new_e.dst_idx = rd;
          end
          4'b0000, 4'b0001, 4'b0010, 4'b0011: begin
            new_e.ctl     = {op, ext};
            new_e.src     = rd_data;
            new_e.src_snp = 1'b1;
            new_e.src_idx = rd;
          end
          default: begin
            new_e.illegal = 1'b1;
            new_e.wb_req  = 1'b0;
          end
        endcase
      end
      4'b0101: begin  // ADDI
        new_e.ctl     = {op, 4'b0000};
        new_e.src     = imm_s;
        new_e.dst     = rd_data;
        new_e.dst_snp = 1'b1;
        new_e.dst_idx = rd;
      end
      4'b0110, 4'b0001, 4'b0010, 4'b0011: begin  // ADDUI, ANDI, ORI, XORI
        new_e.ctl     = {op, 4'b0000};
        new_e.src     = imm_z;
        new_e.dst     = rd_data;
        new_e.dst_snp = 1'b1;
        new_e.dst_idx = rd;
      end
      4'b1001, 4'b1011: begin  // SUBI, CMPI
        new_e.ctl     = {op, 4'b0000};
        new_e.src     = rd_data;
        new_e.src_snp = 1'b1;
        new_e.src_idx = rd;
        new_e.dst     = imm_s;
        new_e.wb_req  = (op != 4'b1011);
      end
      4'b1101, 4'b1111: begin  // MOVI, LUI
        new_e.ctl = {op, 4'b0000};
        new_e.dst = imm_z;
      end
      default: begin  // 0100, 0111, 1010, 1100, 1110
        new_e.illegal = 1'b1;
        new_e.wb_req  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------- 2-entry buffer
  entry_t out_reg, skid_reg, out_next, skid_next, out_snp, skid_snp;
  logic   out_valid_reg, skid_valid_reg, in_ready_reg;
  logic   out_valid_next, skid_valid_next;
  logic   accept, transfer;

  assign accept   = in_valid && in_ready_reg;
  assign transfer = out_valid_reg && out_ready;
  assign out_snp  = snoop_entry(out_reg, wb_en, wb_addr, wb_data);
  assign skid_snp = snoop_entry(skid_reg, wb_en, wb_addr, wb_data);

  // Next-state for output register and skid. in_ready is low whenever the
  // skid is full, so an accept never coincides with a full skid.
  always_comb begin
    out_next        = out_snp;
    skid_next       = skid_snp;
    out_valid_next  = out_valid_reg;
    skid_valid_next = skid_valid_reg;
    if (transfer) begin
      if (skid_valid_reg) begin
        out_next        = skid_snp;
        out_valid_next  = 1'b1;
        skid_valid_next = 1'b0;
      end else begin
        out_valid_next = accept;
        if (accept) out_next = new_e;
      end
    end else if (!out_valid_reg) begin
      out_valid_next = accept;
      if (accept) out_next = new_e;
    end else if (accept) begin
      skid_next       = new_e;
      skid_valid_next = 1'b1;
    end
  end

  // Buffer state; in_ready is registered from the next skid occupancy.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_reg        <= '0;
      skid_reg       <= '0;
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
      in_ready_reg   <= 1'b1;
    end else begin
      out_reg        <= out_next;
      skid_reg       <= skid_next;
      out_valid_reg  <= out_valid_next;
      skid_valid_reg <= skid_valid_next;
      in_ready_reg   <= !skid_valid_next;
    end
  end

  assign in_ready         = in_ready_reg;
  assign out_valid        = out_valid_reg;
  assign alu_enable       = out_valid_reg;
  assign operationControl = out_reg.ctl;
  assign sourceData       = out_reg.src;
  assign destData         = out_reg.dst;
  assign wb_req           = out_reg.wb_req;
  assign wb_dest          = out_reg.wb_dest;
  assign illegal          = out_reg.illegal;

endmodule
